// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side type definitions for memory arbitration
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: generic up counter with synchronous clear and count enable
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  // clear wins over enable; the caller decides when counting should stop
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) count_out <= '0;
    else if (clear) count_out <= '0;
    else if (count_enable) count_out <= count_out + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache with starvation guard
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state, next_state;
  logic [CW-1:0] starve;
  logic dreq, acc, sat;
  assign dreq = dREN | dWEN;
  assign acc  = ramstate == ACCESS;
  assign sat  = starve == CW'(STARVE_LIMIT);
  // grant decision: dcache wins ties until the icache has starved long enough;
  // a dcache grant is held for the whole block so words are never interleaved
  always_comb
    case (state)
      IDLE:    next_state = (dreq && !sat) ? DSERV : iREN ? ISERV : IDLE;
      DSERV:   next_state = dreq ? DSERV : IDLE;
      ISERV:   next_state = (acc || !iREN) ? IDLE : ISERV;
      default: next_state = IDLE;
    endcase
  // state register; reset abandons any transfer in flight
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= next_state;
  // counts denied icache cycles, saturating so the grant condition stays stable
  flex_counter #(.NUM_CNT_BITS(CW)) u_starve (
    .CLK          (CLK),
    .nRST         (nRST),
    .clear        (!iREN || (state != ISERV && next_state == ISERV)),
    .count_enable (iREN && state != ISERV && !sat),
    .count_out    (starve)
  );
  assign ramREN   = state == ISERV || (state == DSERV && dREN && !dWEN);
  assign ramWEN   = state == DSERV && dWEN;
  assign ramaddr  = state == DSERV ? daddr : state == ISERV ? iaddr : '0;
  assign ramstore = state == DSERV ? dstore : '0;
  assign dwait    = !(state == DSERV && acc);
  assign iwait    = !(state == ISERV && acc);
  assign dload    = ramload;
  assign iload    = ramload;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied icache-request cycles that forces an icache grant.
REQ-002 SHALL have CLK  in  1  clock, rising-edge.
REQ-003 SHALL have nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have iREN  in  1  icache read request.
REQ-005 SHALL have iaddr  in  32  icache word address.
REQ-006 SHALL have iwait  out  1  icache stall; 0 means iload is valid this cycle.
REQ-007 SHALL have iload  out  32  icache read data.
REQ-008 SHALL have dREN, dWEN  in  1 each  dcache read and write requests.
REQ-009 SHALL have daddr, dstore  in  32 each  dcache word address and write data.
REQ-010 SHALL have dwait  out  1  dcache stall; 0 means the word is complete this cycle.
REQ-011 SHALL have dload  out  32  dcache read data.
REQ-012 SHALL have ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each; ramload  in  32; ramstate  in  2 (FREE, BUSY, ACCESS, ERROR).

Function
REQ-013 SHALL implement a registered FSM with states IDLE, DSERV and ISERV.
REQ-014 In IDLE: drive ramREN=ramWEN=0, iwait=dwait=1 (one-cycle arbitration bubble).
REQ-015 IDLE->DSERV when (dREN|dWEN) and starve count < STARVE_LIMIT.
REQ-016 IDLE->ISERV when iREN and either no dcache request or starve count = STARVE_LIMIT.
REQ-017 DSERV: ram ports driven combinationally from daddr/dstore.
REQ-018 DSERV: dWEN takes precedence, giving ramWEN=dWEN and ramREN=dREN&~dWEN.
REQ-019 DSERV: dwait = (ramstate != ACCESS) and dload = ramload.
REQ-020 DSERV SHALL hold while dREN|dWEN remains asserted, so a multi-word block transfer is never interleaved even though daddr changes between words.
REQ-021 DSERV->IDLE when dREN=dWEN=0.
REQ-022 ISERV: ramREN=1, ramaddr=iaddr, iwait=(ramstate != ACCESS), iload=ramload.
REQ-023 ISERV->IDLE on the cycle ramstate=ACCESS (single word), or immediately if iREN drops.
REQ-024 The non-granted port's wait SHALL be 1 and its load SHALL be ramload; the ungranted side's data is don't-care.
REQ-025 ramstate ERROR and BUSY SHALL both be treated as not-ACCESS: wait held, no state change, no error latched.
REQ-026 ramstore SHALL be dstore in DSERV and 0 otherwise; ramaddr SHALL be 0 in IDLE.
REQ-027 Starve counter, width clog2(STARVE_LIMIT+1): increments (saturating at STARVE_LIMIT) each cycle iREN=1 and state != ISERV; clears on entering ISERV or whenever iREN=0.
REQ-028 Simultaneous iREN and dcache request in IDLE with counter below limit SHALL grant dcache.

Reset
REQ-029 On nRST low, asynchronously: state=IDLE, starve counter=0; outputs therefore ramREN=ramWEN=0, iwait=dwait=1, ramaddr=ramstore=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no further RAM request.

Structure
REQ-031 The state enum (arb_state_t) and the ramstate encoding SHALL live in the shared cpu_types_pkg; STARVE_LIMIT stays a module parameter.
REQ-032 The starve counter SHALL reuse the existing flex_counter sub-module with saturation logic gating its enable; there are no other sub-modules.
REQ-033 The RAM-side mux SHALL be purely combinational from the registered state (no extra latency beyond the IDLE bubble).

Verification
REQ-034 dREN=1, daddr=0x40, ramstate ACCESS after 2 cycles -> IDLE, DSERV; dwait falls exactly on the ACCESS cycle; dload=ramload.
REQ-035 dREN held while daddr goes 0x40->0x44, with iREN=1 throughout (STARVE_LIMIT=4) -> no ISERV until dREN drops or the counter saturates at 4, then ISERV is entered on the next IDLE.
REQ-036 dWEN=dREN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-037 iREN only, iaddr=0x100, ramload=0x8C220004 on ACCESS -> iload matches, iwait=0 for one cycle, return to IDLE.
REQ-038 ramstate=ERROR for 3 cycles during DSERV, then ACCESS -> dwait stays 1 through ERROR, completes on ACCESS.
REQ-039 nRST pulsed low in DSERV mid-block -> ramREN/ramWEN drop asynchronously; after release, IDLE with counter 0.
